// File: rtl/calendar_rtc.sv
// ---------------------------------------------------------------------------
// calendar_rtc
//
// Second-resolution real-time calendar. It advances the full date and time by
// one second on each tick and applies the Gregorian leap-year rules. It also
// accepts a validated load request for setting the clock. Single-cycle carry
// strobes feed the alarm and chime logic downstream.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   tick              one-cycle strobe, advance by one second
//   mode12            1 = hour12 shows 1..12, 0 = hour12 mirrors hour
//   set_valid         one-cycle load request sampling all set_* fields
//   set_year..set_week  load values
//   set_ack / set_err one-cycle pulse: load accepted / rejected
//   year..week        current calendar registers
//   hour12, pm        display hour and afternoon flag (combinational)
//   leap              current year is a leap year (combinational)
//   min_carry         pulse when second wraps 59 -> 0
//   hour_carry        pulse when minute wraps 59 -> 0
//   day_carry         pulse on the midnight rollover
// ---------------------------------------------------------------------------
module calendar_rtc #(
  parameter int YEAR_W    = 16,
  parameter int RST_YEAR  = 2023,
  parameter int RST_MONTH = 1,
  parameter int RST_DAY   = 1,
  parameter int RST_HOUR  = 0,
  parameter int RST_MIN   = 0,
  parameter int RST_SEC   = 0,
  parameter int RST_WEEK  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              mode12,
  input  logic              set_valid,
  input  logic [YEAR_W-1:0] set_year,
  input  logic [3:0]        set_month,
  input  logic [4:0]        set_day,
  input  logic [4:0]        set_hour,
  input  logic [5:0]        set_min,
  input  logic [5:0]        set_sec,
  input  logic [2:0]        set_week,
  output logic              set_ack,
  output logic              set_err,
  output logic [YEAR_W-1:0] year,
  output logic [3:0]        month,
  output logic [4:0]        day,
  output logic [4:0]        hour,
  output logic [4:0]        hour12,
  output logic              pm,
  output logic [5:0]        minute,
  output logic [5:0]        second,
  output logic [2:0]        week,
  output logic              leap,
  output logic              min_carry,
  output logic              hour_carry,
  output logic              day_carry
);

  // Multiplicative inverse of an odd constant modulo 2^YEAR_W. Newton steps
  // double the number of correct low bits each time, starting from 3 bits.
  function automatic logic [YEAR_W-1:0] odd_inverse(input logic [YEAR_W-1:0] d);
    logic [YEAR_W-1:0] x;
    x = d;
    for (int i = 0; i < 7; i++) begin
      x = x * (YEAR_W'(2) - d * x);
    end
    return x;
  endfunction

  // y is a multiple of 25 exactly when y * inv(25) (mod 2^W) is at most
  // floor((2^W-1)/25). This replaces a divider with one constant multiply and
  // one compare. Combined with the low bits it gives the %100 and %400 terms:
  // %100 == 0  <=>  %4 == 0 and %25 == 0
  // %400 == 0  <=>  %16 == 0 and %25 == 0
  localparam logic [YEAR_W-1:0] INV25      = odd_inverse(YEAR_W'(25));
  localparam logic [YEAR_W-1:0] MAX_MULT25 =
    YEAR_W'(((64'd1 << YEAR_W) - 64'd1) / 64'd25);

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic [YEAR_W-1:0] prod;
    logic              div4;
    logic              div16;
    logic              div25;
    prod  = y * INV25;
    div25 = (prod <= MAX_MULT25);
    div4  = (y[1:0] == 2'd0);
    div16 = (y[3:0] == 4'd0);
    return (div4 && !div25) || (div16 && div25);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic lp);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = lp ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  logic [YEAR_W-1:0] nxt_year;
  logic [3:0]        nxt_month;
  logic [4:0]        nxt_day;
  logic [4:0]        nxt_hour;
  logic [5:0]        nxt_minute;
  logic [5:0]        nxt_second;
  logic [2:0]        nxt_week;
  logic              nxt_ack;
  logic              nxt_err;
  logic              nxt_min_carry;
  logic              nxt_hour_carry;
  logic              nxt_day_carry;

  logic [4:0]        cur_dim;
  logic              set_leap;
  logic [4:0]        set_dim;
  logic              set_ok;

  assign leap     = is_leap(year);
  assign cur_dim  = days_in_month(month, leap);

  // Load validation uses the leap status of the year being loaded, not the
  // year currently held.
  assign set_leap = is_leap(set_year);
  assign set_dim  = days_in_month(set_month, set_leap);
  assign set_ok   = (set_month >= 4'd1) && (set_month <= 4'd12) &&
                    (set_day >= 5'd1) && (set_day <= set_dim) &&
                    (set_hour <= 5'd23) && (set_min <= 6'd59) &&
                    (set_sec <= 6'd59) && (set_week != 3'd0);

  // Display hour: 0 shows as 12, afternoon hours fold down by 12 in 12-hour mode.
  always_comb begin
    hour12 = hour;
    if (mode12) begin
      if (hour == 5'd0) begin
        hour12 = 5'd12;
      end else if (hour > 5'd12) begin
        hour12 = hour - 5'd12;
      end
    end
  end

  assign pm = (hour >= 5'd12);

  // Next-state logic. A load has priority over a tick, and the tick in that
  // cycle is dropped. The whole cascade is resolved here in one cycle, so no
  // out-of-range intermediate value ever reaches a register.
  always_comb begin
    nxt_year       = year;
    nxt_month      = month;
    nxt_day        = day;
    nxt_hour       = hour;
    nxt_minute     = minute;
    nxt_second     = second;
    nxt_week       = week;
    nxt_ack        = 1'b0;
    nxt_err        = 1'b0;
    nxt_min_carry  = 1'b0;
    nxt_hour_carry = 1'b0;
    nxt_day_carry  = 1'b0;

    if (set_valid) begin
      if (set_ok) begin
        nxt_year   = set_year;
        nxt_month  = set_month;
        nxt_day    = set_day;
        nxt_hour   = set_hour;
        nxt_minute = set_min;
        nxt_second = set_sec;
        nxt_week   = set_week;
        nxt_ack    = 1'b1;
      end else begin
        nxt_err    = 1'b1;
      end
    end else if (tick) begin
      if (second >= 6'd59) begin
        nxt_second    = 6'd0;
        nxt_min_carry = 1'b1;
        if (minute >= 6'd59) begin
          nxt_minute     = 6'd0;
          nxt_hour_carry = 1'b1;
          if (hour >= 5'd23) begin
            nxt_hour      = 5'd0;
            nxt_day_carry = 1'b1;
            nxt_week      = (week >= 3'd7) ? 3'd1 : week + 3'd1;
            if (day >= cur_dim) begin
              nxt_day = 5'd1;
              if (month >= 4'd12) begin
                nxt_month = 4'd1;
                // Wraps to 0 at the top of the counter, silently.
                nxt_year  = year + YEAR_W'(1);
              end else begin
                nxt_month = month + 4'd1;
              end
            end else begin
              nxt_day = day + 5'd1;
            end
          end else begin
            nxt_hour = hour + 5'd1;
          end
        end else begin
          nxt_minute = minute + 6'd1;
        end
      end else begin
        nxt_second = second + 6'd1;
      end
    end
  end

  // State registers. Reset discards any load that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      year       <= YEAR_W'(RST_YEAR);
      month      <= 4'(RST_MONTH);
      day        <= 5'(RST_DAY);
      hour       <= 5'(RST_HOUR);
      minute     <= 6'(RST_MIN);
      second     <= 6'(RST_SEC);
      week       <= 3'(RST_WEEK);
      set_ack    <= 1'b0;
      set_err    <= 1'b0;
      min_carry  <= 1'b0;
      hour_carry <= 1'b0;
      day_carry  <= 1'b0;
    end else begin
      year       <= nxt_year;
      month      <= nxt_month;
      day        <= nxt_day;
      hour       <= nxt_hour;
      minute     <= nxt_minute;
      second     <= nxt_second;
      week       <= nxt_week;
      set_ack    <= nxt_ack;
      set_err    <= nxt_err;
      min_carry  <= nxt_min_carry;
      hour_carry <= nxt_hour_carry;
      day_carry  <= nxt_day_carry;
    end
  end

endmodule
